pair_scheduler: RTL and testbench



---
 rtl/pair_scheduler.sv | 151 +++++++++++++++
 tb/tb_pair_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pair_scheduler.sv
// Issue-side sequencer for the N-body force phase: walks all ordered pairs (i, j), i != j,
// one per cycle, and delays valid/first/last/i tags to line up with RAM data and pipe output.
module pair_scheduler #(
    parameter int unsigned BODIES          = 512,
    parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int unsigned RAM_LATENCY     = 2,
    parameter int unsigned PIPE_LATENCY    = 80
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
    output logic [BODY_ADDR_WIDTH-1:0] rd_addr_i,
    output logic [BODY_ADDR_WIDTH-1:0] rd_addr_j,
    output logic                       rd_valid,
    output logic                       ram_valid,
    output logic                       acc_valid,
    output logic                       acc_first,
    output logic                       acc_last,
    output logic [BODY_ADDR_WIDTH-1:0] acc_i,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned W = BODY_ADDR_WIDTH;
    localparam int unsigned R = RAM_LATENCY;
    localparam int unsigned P = PIPE_LATENCY;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    typedef struct packed {
        logic         first;
        logic         last;
        logic [W-1:0] idx;
    } tag_t;

    state_e       state_q, state_d;
    logic [W-1:0] n_q, n_d, i_q, i_d, j_q, j_d;
    logic         rd_valid_q, rd_valid_d;
    logic         tag_first, tag_last, final_pair, lines_empty;

    // Each chain has one extra element: index 0 is the feed, the top index is the output tap.
    logic [R:0]   rv_in;
    logic [R-1:0] rv_q;
    tag_t         rt_in [R+1];
    tag_t         rt_q  [R];
    logic [P:0]   av_in;
    logic [P-1:0] av_q;
    tag_t         at_in [P+1];
    tag_t         at_q  [P];

    assign tag_first   = (i_q == '0) ? (j_q == W'(1)) : (j_q == '0);
    assign tag_last    = (i_q == n_q - W'(1)) ? (j_q == n_q - W'(2)) : (j_q == n_q - W'(1));
    assign final_pair  = rd_valid_q && tag_last && (i_q == n_q - W'(1));
    assign lines_empty = ~|rv_q && ~|av_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (!rd_valid_q || final_pair) state_d = StDrain;
            StDrain: if (lines_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDrain) && lines_empty;
    end

    always_comb begin
        n_d        = n_q;
        i_d        = i_q;
        j_d        = j_q;
        rd_valid_d = rd_valid_q;
        if (state_q == StIdle && start) begin
            n_d        = num_bodies;
            i_d        = '0;
            j_d        = W'(1);
            rd_valid_d = (num_bodies >= W'(2));
        end else if (state_q == StIssue && rd_valid_q) begin
            if (final_pair) begin
                rd_valid_d = 1'b0;
            end else if (tag_last) begin
                // Rows after the first always start at j = 0.
                i_d = i_q + W'(1);
                j_d = '0;
            end else if (j_q + W'(1) == i_q) begin
                j_d = j_q + W'(2);
            end else begin
                j_d = j_q + W'(1);
            end
        end
        if (abort) rd_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        rv_in    = {rv_q, rd_valid_q};
        rt_in[0] = '{first: tag_first, last: tag_last, idx: i_q};
        for (int k = 0; k < int'(R); k++) rt_in[k+1] = rt_q[k];
        av_in    = {av_q, rv_in[R]};
        at_in[0] = rt_in[R];
        for (int k = 0; k < int'(P); k++) at_in[k+1] = at_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q <= '0;
            av_q <= '0;
            for (int k = 0; k < int'(R); k++) rt_q[k] <= '0;
            for (int k = 0; k < int'(P); k++) at_q[k] <= '0;
        end else begin
            rv_q <= abort ? '0 : rv_in[R-1:0];
            av_q <= abort ? '0 : av_in[P-1:0];
            for (int k = 0; k < int'(R); k++) rt_q[k] <= rt_in[k];
            for (int k = 0; k < int'(P); k++) at_q[k] <= at_in[k];
        end
    end

    assign rd_addr_i = i_q;
    assign rd_addr_j = j_q;
    assign rd_valid  = rd_valid_q;
    assign ram_valid = rv_in[R];
    assign acc_valid = av_in[P];
    assign acc_first = av_in[P] & at_in[P].first;
    assign acc_last  = av_in[P] & at_in[P].last;
    assign acc_i     = av_in[P] ? at_in[P].idx : '0;

endmodule

// File: tb/tb_pair_scheduler.sv
// Bench for pair_scheduler: directed passes from the test plan plus randomized passes,
// each cycle checked against a pair-index model computed from the walk order.
module tb_pair_scheduler;

    localparam int R = 2;
    localparam int P = 80;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] num_bodies = '0;
    logic [W-1:0] rd_addr_i, rd_addr_j, acc_i;
    logic         rd_valid, ram_valid, acc_valid, acc_first, acc_last, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pair_scheduler #(
        .BODIES      (512),
        .RAM_LATENCY (R),
        .PIPE_LATENCY(P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_bodies(num_bodies),
        .rd_addr_i (rd_addr_i),
        .rd_addr_j (rd_addr_j),
        .rd_valid  (rd_valid),
        .ram_valid (ram_valid),
        .acc_valid (acc_valid),
        .acc_first (acc_first),
        .acc_last  (acc_last),
        .acc_i     (acc_i),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".rd_addr_i"}, 32'(rd_addr_i), 0);
        check_eq({tag, ".rd_addr_j"}, 32'(rd_addr_j), 0);
        check_eq({tag, ".acc_first"}, 32'(acc_first), 0);
        check_eq({tag, ".acc_last"}, 32'(acc_last), 0);
        check_eq({tag, ".acc_i"}, 32'(acc_i), 0);
    endtask

    // Cycle 0 is the cycle in which start is driven; abort_at/again_at/rst_at < 0 disables them.
    task automatic run_pass(input int n, input int abort_at, input int again_at, input int rst_at,
                            input bit garble, input int len_override);
        int  l, d, last_c, kr, ka, ri, rj, jj, ai, pos;
        bit  cut, rv, mv, av;
        l      = n * (n - 1);
        d      = (n < 2) ? 2 : l + R + P + 1;
        last_c = (len_override > 0) ? len_override - 1 : d + 2;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            cyc   = c;
            start = (c == 0) || (c == again_at);
            abort = (c == abort_at);
            if (c == 0) num_bodies = W'(n);
            else if (garble) num_bodies = W'($urandom_range(0, 7));
            if (c == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && c == rst_at + 2) rst_n = 1'b1;
            @(negedge clk);
            cut = (abort_at >= 0 && c > abort_at) || (rst_at >= 0 && c >= rst_at);
            kr  = c - 1;
            ka  = c - 1 - R - P;
            rv  = !cut && kr >= 0 && kr < l;
            mv  = !cut && kr - R >= 0 && kr - R < l;
            av  = !cut && ka >= 0 && ka < l;
            check_eq("rd_valid", 32'(rd_valid), 32'(rv));
            check_eq("ram_valid", 32'(ram_valid), 32'(mv));
            check_eq("acc_valid", 32'(acc_valid), 32'(av));
            check_eq("busy", 32'(busy), 32'(!cut && c >= 1 && c <= d));
            check_eq("done", 32'(done), 32'(!cut && c == d));
            if (rv) begin
                ri = kr / (n - 1);
                jj = kr % (n - 1);
                rj = (jj < ri) ? jj : jj + 1;
                check_eq("rd_addr_i", 32'(rd_addr_i), 32'(ri));
                check_eq("rd_addr_j", 32'(rd_addr_j), 32'(rj));
            end
            if (av) begin
                ai  = ka / (n - 1);
                pos = ka % (n - 1);
                check_eq("acc_i", 32'(acc_i), 32'(ai));
                check_eq("acc_first", 32'(acc_first), 32'(pos == 0));
                check_eq("acc_last", 32'(acc_last), 32'(pos == n - 2));
            end
            if (rst_at >= 0 && c >= rst_at && c < rst_at + 2) check_all_zero("in_reset");
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int n, d, mode;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset.rd_valid", 32'(rd_valid), 0);
        check_eq("reset.ram_valid", 32'(ram_valid), 0);
        check_eq("reset.acc_valid", 32'(acc_valid), 0);
        check_eq("reset.busy", 32'(busy), 0);
        check_eq("reset.done", 32'(done), 0);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_pass(3, -1, -1, -1, 1'b0, 0);
        run_pass(1, -1, -1, -1, 1'b0, 0);
        run_pass(0, -1, -1, -1, 1'b0, 0);
        run_pass(2, -1, -1, -1, 1'b0, 0);
        run_pass(3, 4, -1, -1, 1'b0, 10);
        run_pass(3, -1, -1, -1, 1'b0, 0);
        run_pass(3, -1, 3, -1, 1'b0, 0);
        run_pass(3, -1, -1, 50, 1'b0, 0);
        run_pass(3, 0, -1, -1, 1'b0, 5);
        run_pass(4, -1, -1, -1, 1'b1, 0);

        for (int t = 0; t < 12; t++) begin
            n    = $urandom_range(0, 7);
            d    = (n < 2) ? 2 : n * (n - 1) + R + P + 1;
            mode = $urandom_range(0, 3);
            case (mode)
                0: run_pass(n, -1, -1, -1, 1'($urandom_range(0, 1)), 0);
                1: run_pass(n, -1, $urandom_range(1, d), -1, 1'b1, 0);
                2: begin
                    int a;
                    a = $urandom_range(0, d);
                    run_pass(n, a, -1, -1, 1'b0, a + 3);
                end
                default: run_pass(n, -1, -1, $urandom_range(1, d), 1'b0, 0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
